// File: rtl/next_level_req_queue_pkg.sv
// Shared cache definitions: line-address geometry, trace command codes
// and the request bundle carried from L1 toward the next-level cache.
package cache_pkg;

    localparam int LINE_ADDR_W = 26;
    localparam int OFFSET_BITS = 6;

    typedef enum logic [3:0] {
        READ       = 4'd0,
        WRITE      = 4'd1,
        INVALIDATE = 4'd3,
        RESET      = 4'd8,
        PRINT      = 4'd9
    } trace_cmd_e;

    typedef struct packed {
        logic [LINE_ADDR_W-1:0] line_addr;
        logic                   write;
    } req_t;

endpackage

// File: rtl/next_level_req_queue_if.sv
// Request-in / request-out handshake bundle between L1, the queue and L2.
// master = the side driving requests in and accepting them out.
interface nlq_if #(
    parameter int ADDR_W = cache_pkg::LINE_ADDR_W
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic              in_write;
    logic              in_ready;
    logic              out_valid;
    logic [ADDR_W-1:0] out_addr;
    logic              out_write;
    logic              out_ready;

    modport master (
        output in_valid, in_addr, in_write, out_ready,
        input  in_ready, out_valid, out_addr, out_write
    );

    modport slave (
        input  in_valid, in_addr, in_write, out_ready,
        output in_ready, out_valid, out_addr, out_write
    );
endinterface

// File: rtl/next_level_req_queue_storage.sv
// Request entry array: one write port, head read port and tail read port
// (the tail port feeds the coalescing comparator).
module nlq_storage #(
    parameter int DEPTH = 8,
    parameter int W     = 27
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [W-1:0]             rdata,
    input  logic [$clog2(DEPTH)-1:0] tail_ptr,
    output logic [W-1:0]             tail_data
);
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr] <= wdata;
    end

    assign rdata     = mem_q[rd_ptr];
    assign tail_data = mem_q[tail_ptr];
endmodule

// File: rtl/next_level_req_queue.sv
// Coalescing request FIFO from L1 toward the next-level cache, with
// drop/merge statistics. Occupancy alone encodes EMPTY/PARTIAL/FULL.
import cache_pkg::*;

module next_level_req_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = LINE_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    nlq_if.slave                   bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       drops,
    output logic [CNT_W-1:0]       merged
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] drops_q, drops_d;
    logic [CNT_W-1:0] merged_q, merged_d;

    logic [ADDR_W:0] head_data, tail_data;
    logic            full_w, empty_w, pop, push, coalesce;
    logic            accept, tail_hit;

    nlq_storage #(.DEPTH(DEPTH), .W(ADDR_W + 1)) u_storage (
        .clk       (clk),
        .we        (push && !flush),
        .wr_ptr    (wr_ptr_q),
        .wdata     ({bus.in_addr, bus.in_write}),
        .rd_ptr    (rd_ptr_q),
        .rdata     (head_data),
        .tail_ptr  (wr_ptr_q - PW'(1)),
        .tail_data (tail_data)
    );

    always_comb begin
        full_w   = count_q == CW'(DEPTH);
        empty_w  = count_q == '0;
        pop      = !empty_w && bus.out_ready;
        accept   = bus.in_valid && !full_w;
        tail_hit = tail_data == {bus.in_addr, bus.in_write};
        // A tail leaving this cycle can no longer absorb the request.
        coalesce = accept && !empty_w && tail_hit
                   && !(count_q == CW'(1) && pop);
        push     = accept && !coalesce;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drops_d  = drops_q;
        merged_d = merged_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop) count_d = count_q + CW'(1);
        if (pop && !push) count_d = count_q - CW'(1);

        if (bus.in_valid && full_w && drops_q != '1)
            drops_d = drops_q + CNT_W'(1);
        if (coalesce && merged_q != '1)
            merged_d = merged_q + CNT_W'(1);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drops_q  <= '0;
            merged_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drops_q  <= drops_d;
            merged_q <= merged_d;
        end
    end

    assign bus.in_ready  = !full_w;
    assign bus.out_valid = !empty_w;
    assign bus.out_addr  = head_data[ADDR_W:1];
    assign bus.out_write = head_data[0];

    assign count  = count_q;
    assign full   = full_w;
    assign empty  = empty_w;
    assign drops  = drops_q;
    assign merged = merged_q;
endmodule
